// File: rtl/iob_uart_tx_arb_pkg.sv
// Shared state encoding and round-robin helper for the
// UART TX arbiter and its RX-side sibling distributors.
package iob_uart_tx_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_GUARD = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SEND  = ST_SEND,
    ISSUE = ST_ISSUE,
    GUARD = ST_GUARD
  } arb_state_e;

  localparam int RR_MAX = 8;

  // First set bit of req at or after ptr, wrapping within n entries.
  function automatic logic [RR_MAX-1:0] rr_pick(
    input logic [RR_MAX-1:0] req,
    input logic [2:0]        ptr,
    input logic [3:0]        n
  );
    logic [RR_MAX-1:0] gnt;
    logic              found;
    logic [3:0]        idx;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < RR_MAX; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= n) idx = idx - n;
      if ((4'(i) < n) && !found && req[idx[2:0]]) begin
        gnt[idx[2:0]] = 1'b1;
        found         = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/iob_uart_rr_picker.sv
// Combinational round-robin picker: one-hot grant from a
// request vector and a priority pointer.
module iob_uart_rr_picker
  import iob_uart_tx_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  logic [RR_MAX-1:0] req_pad;
  logic [RR_MAX-1:0] gnt_pad;
  logic [2:0]        ptr_pad;

  always_comb begin
    req_pad          = '0;
    req_pad[N-1:0]   = req_i;
    ptr_pad          = '0;
    ptr_pad[PTR_W-1:0] = ptr_i;
    gnt_pad          = rr_pick(req_pad, ptr_pad, 4'(N));
  end

  assign gnt_o = gnt_pad[N-1:0];

  if (N < RR_MAX) begin : g_pad
    logic unused_hi;
    assign unused_hi = |gnt_pad[RR_MAX-1:N];
  end

endmodule

// File: rtl/iob_uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_core
// transmit path between N_REQ byte-stream producers.
module iob_uart_tx_arbiter
  import iob_uart_tx_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int TMO_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic [TMO_W-1:0]        tmo_cycles_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  input  logic [N_REQ-1:0]        req_last_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic                    tx_ready_i,
  output logic [DATA_W-1:0]       tx_data_o,
  output logic                    tx_wen_o,
  output logic [N_REQ-1:0]        grant_o,
  output logic                    busy_o,
  output logic                    tmo_o
);

  localparam int PTR_W = $clog2(N_REQ);

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  gidx_q, gidx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              wen_q, wen_d;
  logic              tmo_q, tmo_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;

  logic [N_REQ-1:0]  pick;
  logic [PTR_W-1:0]  pick_idx;
  logic [PTR_W-1:0]  ptr_nxt;
  logic [DATA_W-1:0] g_data;
  logic              g_valid;
  logic              g_last;
  logic              can_take;
  logic              accept;
  logic [TMO_W-1:0]  cnt_inc;
  logic              cnt_hit;

  iob_uart_rr_picker #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (pick)
  );

  always_comb begin
    pick_idx = '0;
    g_data   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) pick_idx = PTR_W'(i);
      if (grant_q[i]) g_data = req_data_i[i*DATA_W +: DATA_W];
    end
  end

  assign g_valid  = |(req_valid_i & grant_q);
  assign g_last   = |(req_last_i & grant_q);
  assign can_take = (state_q == SEND) && en_i && tx_ready_i;
  assign accept   = can_take && g_valid;
  assign ptr_nxt  = (gidx_q == PTR_W'(N_REQ-1)) ? '0
                  : gidx_q + PTR_W'(1);
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + TMO_W'(1);
  assign cnt_hit  = (tmo_cycles_i != '0)
                 && (cnt_inc >= tmo_cycles_i);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    data_d  = data_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    wen_d   = 1'b0;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_i && |req_valid_i) begin
          grant_d = pick;
          gidx_d  = pick_idx;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          data_d  = g_data;
          last_d  = g_last;
          cnt_d   = '0;
          wen_d   = 1'b1;
          state_d = ISSUE;
        end else if (en_i && !g_valid) begin
          cnt_d = cnt_inc;
          if (cnt_hit) begin
            grant_d = '0;
            ptr_d   = ptr_nxt;
            cnt_d   = '0;
            tmo_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      ISSUE: state_d = GUARD;
      GUARD: begin
        // uart_core drops tx_ready one cycle late; skip that cycle
        if (last_q) begin
          grant_d = '0;
          ptr_d   = ptr_nxt;
          state_d = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      gidx_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      wen_q   <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      data_q  <= data_d;
      last_q  <= last_d;
      wen_q   <= wen_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready_o = can_take ? grant_q : '0;
  assign tx_data_o   = data_q;
  assign tx_wen_o    = wen_q;
  assign grant_o     = grant_q;
  assign busy_o      = |grant_q;
  assign tmo_o       = tmo_q;

endmodule

// File: tb/tb_iob_uart_tx_arbiter.sv
// Directed bench for iob_uart_tx_arbiter: byte queues per
// requester, a uart_core ready model and strobe/timeout logs.
module tb_iob_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] tmo;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_wen;
  logic [3:0]  grant;
  logic        busy;
  logic        tmo_p;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [8:0] mem [4][32];
  logic [4:0] head [4];
  logic [4:0] tail [4];
  logic       flush = 1'b0;

  logic       rdy_mode = 1'b0;
  int         rdy_cnt  = 0;

  logic [7:0] slog [64];
  int         scyc [64];
  logic [3:0] sgnt [64];
  int         sn = 0;
  int         acyc [64];
  int         an = 0;
  int         tcyc = 0;
  logic [3:0] tgnt = '0;
  int         tn = 0;

  iob_uart_tx_arbiter #(
    .N_REQ  (4),
    .DATA_W (8),
    .TMO_W  (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .tmo_cycles_i (tmo),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_last_i   (req_last),
    .req_ready_o  (req_ready),
    .tx_ready_i   (tx_ready),
    .tx_data_o    (tx_data),
    .tx_wen_o     (tx_wen),
    .grant_o      (grant),
    .busy_o       (busy),
    .tmo_o        (tmo_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      req_valid[k]       = head[k] != tail[k];
      req_data[k*8 +: 8] = mem[k][head[k]][7:0];
      req_last[k]        = mem[k][head[k]][8];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (flush) head[k] <= tail[k];
      else if (req_valid[k] && req_ready[k]) head[k] <= head[k] + 5'd1;
    end
  end

  // uart_core stand-in: busy for 10 cycles after each write strobe
  always @(posedge clk) begin
    if (rst) rdy_cnt <= 0;
    else if (tx_wen) rdy_cnt <= 10;
    else if (rdy_cnt != 0) rdy_cnt <= rdy_cnt - 1;
  end
  assign tx_ready = rdy_mode ? (rdy_cnt == 0) : 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("ready_onehot", {31'd0, $onehot0(req_ready)}, 32'd1);
      chk("ready_granted", {28'd0, req_ready & ~grant}, 32'd0);
    end
    if (tx_wen) begin
      slog[sn] = tx_data;
      scyc[sn] = cyc;
      sgnt[sn] = grant;
      sn++;
    end
    if (|(req_valid & req_ready)) begin
      acyc[an] = cyc;
      an++;
    end
    if (tmo_p) begin
      tcyc = cyc;
      tgnt = grant;
      tn++;
    end
  end

  task automatic push(input logic [1:0] k, input logic [7:0] d,
                      input logic l);
    mem[k][tail[k]] = {l, d};
    tail[k] = tail[k] + 5'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int sb;
    int ab;
    int t0;
    logic acc_rdy;
    logic acc_wen;
    logic acc_tmo;
    for (int k = 0; k < 4; k++) begin
      head[k] = '0;
      tail[k] = '0;
      for (int j = 0; j < 32; j++) mem[k][j] = '0;
    end
    rst = 1'b1;
    en  = 1'b1;
    tmo = 16'd0;
    repeat (3) tick();

    // reset state
    @(negedge clk);
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_wen", {31'd0, tx_wen}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tmo", {31'd0, tmo_p}, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    tick();
    rst = 1'b0;

    // single requester, slow uart_core
    rdy_mode = 1'b1;
    tick();
    sb = sn;
    ab = an;
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b1);
    @(negedge clk);
    chk("t1_grant_lat0", {28'd0, grant}, 32'd0);
    @(negedge clk);
    chk("t1_grant", {28'd0, grant}, 32'h1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 100 && !(sn == sb + 2 && grant == 4'd0); i++)
      @(negedge clk);
    chk("t1_done", {31'd0, sn == sb + 2 && grant == 4'd0}, 32'd1);
    chk("t1_d0", {24'd0, slog[sb]}, 32'h41);
    chk("t1_d1", {24'd0, slog[sb+1]}, 32'h42);
    chk("t1_lat0", scyc[sb] - acyc[ab], 32'd1);
    chk("t1_lat1", scyc[sb+1] - acyc[ab+1], 32'd1);
    chk("t1_g0", {28'd0, sgnt[sb]}, 32'h1);
    chk("t1_g1", {28'd0, sgnt[sb+1]}, 32'h1);
    chk("t1_space", {31'd0, scyc[sb+1] - scyc[sb] >= 3}, 32'd1);

    // round-robin fairness from a fresh pointer
    rdy_mode = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb = sn;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++)
        push(2'(k), 8'(8'h10 + k), 1'b1);
    for (int i = 0; i < 200 && sn < sb + 8; i++) @(negedge clk);
    chk("t2_count", sn - sb, 32'd8);
    chk("t2_s0", {24'd0, slog[sb]}, 32'h10);
    chk("t2_s1", {24'd0, slog[sb+1]}, 32'h11);
    chk("t2_s2", {24'd0, slog[sb+2]}, 32'h12);
    chk("t2_s3", {24'd0, slog[sb+3]}, 32'h13);
    chk("t2_s4", {24'd0, slog[sb+4]}, 32'h10);
    chk("t2_s5", {24'd0, slog[sb+5]}, 32'h11);
    chk("t2_s7", {24'd0, slog[sb+7]}, 32'h13);

    // packet lock: r1 holds the path while r2 waits
    for (int i = 0; i < 50 && grant != 4'd0; i++) @(negedge clk);
    tick();
    sb = sn;
    push(1, 8'hA0, 1'b0);
    push(1, 8'hA1, 1'b0);
    push(1, 8'hA2, 1'b1);
    push(2, 8'hB0, 1'b1);
    for (int i = 0; i < 200 && sn < sb + 4; i++) @(negedge clk);
    chk("t3_count", sn - sb, 32'd4);
    chk("t3_s0", {24'd0, slog[sb]}, 32'hA0);
    chk("t3_s1", {24'd0, slog[sb+1]}, 32'hA1);
    chk("t3_s2", {24'd0, slog[sb+2]}, 32'hA2);
    chk("t3_s3", {24'd0, slog[sb+3]}, 32'hB0);

    // idle timeout revokes r2, r3 goes next
    for (int i = 0; i < 50 && grant != 4'd0; i++) @(negedge clk);
    tick();
    tmo = 16'd5;
    sb = sn;
    t0 = tn;
    push(2, 8'hC0, 1'b0);
    for (int i = 0; i < 50 && grant != 4'b0100; i++) @(negedge clk);
    chk("t4_grant_r2", {28'd0, grant}, 32'h4);
    push(3, 8'hD0, 1'b1);
    for (int i = 0; i < 50 && tn == t0; i++) @(negedge clk);
    chk("t4_tmo_count", tn - t0, 32'd1);
    chk("t4_tmo_delay", tcyc - scyc[sb], 32'd7);
    chk("t4_tmo_grant", {28'd0, tgnt}, 32'd0);
    for (int i = 0; i < 50 && sn < sb + 2; i++) @(negedge clk);
    chk("t4_d3", {24'd0, slog[sb+1]}, 32'hD0);
    chk("t4_g3", {28'd0, sgnt[sb+1]}, 32'h8);
    chk("t4_g3_lat", scyc[sb+1] - tcyc, 32'd2);

    // enable low while granted
    for (int i = 0; i < 50 && grant != 4'd0; i++) @(negedge clk);
    tick();
    sb = sn;
    t0 = tn;
    push(0, 8'hE0, 1'b1);
    tick();
    en = 1'b0;
    acc_rdy = 1'b0;
    acc_wen = 1'b0;
    acc_tmo = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc_rdy |= |req_ready;
      acc_wen |= tx_wen;
      acc_tmo |= tmo_p;
    end
    chk("t5_no_ready", {31'd0, acc_rdy}, 32'd0);
    chk("t5_no_wen", {31'd0, acc_wen}, 32'd0);
    chk("t5_no_tmo", {31'd0, acc_tmo}, 32'd0);
    chk("t5_grant", {28'd0, grant}, 32'h1);
    tick();
    en = 1'b1;
    @(negedge clk);
    chk("t5_ready", {28'd0, req_ready}, 32'h1);
    @(negedge clk);
    chk("t5_wen", {31'd0, tx_wen}, 32'd1);
    chk("t5_data", {24'd0, tx_data}, 32'hE0);

    // reset while a strobe is on the wire
    for (int i = 0; i < 50 && grant != 4'd0; i++) @(negedge clk);
    tick();
    push(1, 8'hF0, 1'b0);
    push(1, 8'hF1, 1'b1);
    for (int i = 0; i < 50 && !tx_wen; i++) @(negedge clk);
    chk("t6_issue", {24'd0, tx_data}, 32'hF0);
    rst   = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("t6_wen", {31'd0, tx_wen}, 32'd0);
    chk("t6_grant", {28'd0, grant}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_data", {24'd0, tx_data}, 32'd0);
    chk("t6_tmo", {31'd0, tmo_p}, 32'd0);
    sb = sn;
    tick();
    rst   = 1'b0;
    flush = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_quiet", sn - sb, 32'd0);
    tick();
    push(0, 8'h55, 1'b1);
    push(1, 8'h66, 1'b1);
    @(negedge clk);
    chk("t6_lat0", {28'd0, grant}, 32'd0);
    @(negedge clk);
    chk("t6_r0_wins", {28'd0, grant}, 32'h1);
    for (int i = 0; i < 50 && sn < sb + 2; i++) @(negedge clk);
    chk("t6_count", sn - sb, 32'd2);
    chk("t6_s0", {24'd0, slog[sb]}, 32'h55);
    chk("t6_s1", {24'd0, slog[sb+1]}, 32'h66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
